// File: rtl/ram_pkg.sv
// Shared definitions for the RAM initiator: FSM state encoding and default
// widths that must agree with the RAM instance.
package ram_pkg;

    localparam int unsigned RAM_DATA_WIDTH = 8;
    localparam int unsigned RAM_ADDR_WIDTH = 16;
    localparam int unsigned RAM_LEN_WIDTH  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr   = 2'd1,
        StRd   = 2'd2
    } state_e;

endpackage

// File: rtl/ram_burst_cnt.sv
// Burst address/beat counter: loads start address and beats-1, then steps the
// address (wrapping) and counts remaining beats down; last marks the final beat.
module ram_burst_cnt
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = RAM_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [LEN_WIDTH-1:0]  load_len,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load) begin
            addr_d = load_addr;
            rem_d  = load_len;
        end else if (step) begin
            // Natural overflow gives the 2**ADDR_WIDTH-1 -> 0 wrap.
            addr_d = addr_q + ADDR_WIDTH'(1);
            rem_d  = rem_q - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr = addr_q;
    assign last = (rem_q == '0);

endmodule

// File: rtl/ram_master.sv
// Burst initiator for the single-port synchronous RAM: converts valid/ready
// burst requests into RAM write/read cycles and a registered read-data stream.
module ram_master
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = RAM_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_x,
    input  logic [DATA_WIDTH-1:0] mem_y
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  cnt_load, cnt_step, cnt_last;
    logic [ADDR_WIDTH-1:0] cnt_addr;

    ram_burst_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cnt_load),
        .step      (cnt_step),
        .load_addr (req_addr),
        .load_len  (req_len),
        .addr      (cnt_addr),
        .last      (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        cnt_load   = 1'b0;
        cnt_step   = 1'b0;
        req_ready  = 1'b0;
        wr_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_x      = '0;

        // Consumed beat drops valid; a capture below overrides this.
        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                req_ready = !rd_valid_q;
                if (req_valid && !rd_valid_q) begin
                    cnt_load = 1'b1;
                    state_d  = req_write ? StWr : StRd;
                end
            end
            StWr: begin
                wr_ready = 1'b1;
                mem_x    = wr_data;
                mem_we   = wr_valid;
                if (wr_valid) begin
                    cnt_step = 1'b1;
                    if (cnt_last) begin
                        state_d = StIdle;
                    end
                end
            end
            StRd: begin
                mem_re = 1'b1;
                // mem_y is only looked at here, while the RAM is driving it.
                if (!rd_valid_q || rd_ready) begin
                    rd_data_d  = mem_y;
                    rd_valid_d = 1'b1;
                    cnt_step   = 1'b1;
                    if (cnt_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign mem_a    = cnt_addr;
    assign busy     = (state_q != StIdle);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master with a behavioural single-port RAM:
// table of burst transactions plus hand-written stall, gap, reset and busy cases.
module tb_ram_master;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic          busy;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_x;
    wire  [DW-1:0] mem_y;

    int errors = 0;
    int checks = 0;
    int excl_viol = 0;

    ram_master #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_a     (mem_a),
        .mem_x     (mem_x),
        .mem_y     (mem_y)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: writes on posedge, latches read on negedge, drives bus only while re.
    logic [DW-1:0] ram [0:65535];
    logic [DW-1:0] ram_q;

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] <= '0;
        ram_q <= '0;
    end

    always @(posedge clk) if (mem_we) ram[mem_a] <= mem_x;
    always @(negedge clk) if (mem_re) ram_q <= ram[mem_a];
    assign mem_y = mem_re ? ram_q : 8'hzz;

    always @(posedge clk) begin
        if (mem_we && mem_re) excl_viol++;
        assert (!(mem_we && mem_re)) else $error("mem_we and mem_re both high");
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // gap bit c set -> wr_valid low in cycle c after accept.
    task automatic write_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                               input logic [31:0] data, input logic [31:0] gap);
        int k;
        logic [AW-1:0] a;
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len;
        #1;
        check("wr req_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && k <= int'(len); c++) begin
            wr_valid = !gap[c];
            wr_data  = gap[c] ? 8'hEE : data[8*k +: 8];
            #1;
            check("wr mem_we", {31'd0, mem_we}, {31'd0, wr_valid});
            check("wr busy", {31'd0, busy}, 32'd1);
            if (wr_valid) begin
                a = addr + AW'(k);
                check("wr mem_a", {16'd0, mem_a}, {16'd0, a});
                check("wr mem_x", {24'd0, mem_x}, {24'd0, data[8*k +: 8]});
                k++;
            end
            step();
        end
        wr_valid = 1'b0;
        #1;
        check("wr beats", k, int'(len) + 1);
        check("wr done busy", {31'd0, busy}, 32'd0);
        check("wr done req_ready", {31'd0, req_ready}, 32'd1);
        check("wr done mem_x", {24'd0, mem_x}, 32'd0);
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + AW'(i);
            check("ram contents", {24'd0, ram[a]}, {24'd0, data[8*i +: 8]});
        end
    endtask

    // stall bit c set -> rd_ready low in cycle c after accept.
    task automatic read_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                              input logic [31:0] exp, input logic [31:0] stall);
        int k;
        int first_c;
        logic [AW-1:0] a;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
        rd_ready = 1'b1;
        #1;
        check("rd req_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        k = 0;
        first_c = -1;
        for (int c = 0; c < 40 && k <= int'(len); c++) begin
            rd_ready = !stall[c];
            #1;
            if (rd_valid && first_c < 0) first_c = c;
            if (rd_valid && rd_ready) begin
                check("rd data", {24'd0, rd_data}, {24'd0, exp[8*k +: 8]});
                k++;
            end else if (rd_valid) begin
                a = addr + AW'(k + 1);
                check("rd stall mem_a", {16'd0, mem_a}, {16'd0, a});
                check("rd stall data", {24'd0, rd_data}, {24'd0, exp[8*k +: 8]});
            end
            step();
        end
        rd_ready = 1'b1;
        #1;
        check("rd latency", first_c, 1);
        check("rd beats", k, int'(len) + 1);
        check("rd no extra beat", {31'd0, rd_valid}, 32'd0);
        check("rd done busy", {31'd0, busy}, 32'd0);
        check("rd done req_ready", {31'd0, req_ready}, 32'd1);
        check("rd done mem_re", {31'd0, mem_re}, 32'd0);
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [31:0]   data;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{1'b1, 16'h1234, 4'd0, 32'h0000_00A5};
        vecs[1] = '{1'b0, 16'h1234, 4'd0, 32'h0000_00A5};
        vecs[2] = '{1'b1, 16'hFFFE, 4'd2, 32'h0033_2211};
        vecs[3] = '{1'b0, 16'hFFFE, 4'd2, 32'h0033_2211};

        // Reset state.
        #2;
        check("rst mem_we", {31'd0, mem_we}, 32'd0);
        check("rst mem_re", {31'd0, mem_re}, 32'd0);
        check("rst mem_a", {16'd0, mem_a}, 32'd0);
        check("rst mem_x", {24'd0, mem_x}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst rd_data", {24'd0, rd_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post-rst req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].wr) write_burst(vecs[i].addr, vecs[i].len, vecs[i].data, 32'd0);
            else            read_burst(vecs[i].addr, vecs[i].len, vecs[i].data, 32'd0);
        end
        check("wrap ram[0000]", {24'd0, ram[16'h0000]}, 32'h33);

        // Write with wr_valid gaps, then read with rd_ready low for three cycles.
        write_burst(16'h0100, 4'd3, 32'h4342_4140, 32'b0101_0);
        read_burst(16'h0100, 4'd3, 32'h4342_4140, 32'b11100);

        // Request while busy is refused and not remembered.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0300; req_len = 4'd1;
        #1;
        step();
        req_write = 1'b0; req_addr = 16'h0400; req_len = 4'd0;
        wr_valid = 1'b1; wr_data = 8'h77;
        #1;
        check("busy req_ready", {31'd0, req_ready}, 32'd0);
        step();
        req_valid = 1'b0;
        wr_data = 8'h78;
        #1;
        check("busy req_ready 2", {31'd0, req_ready}, 32'd0);
        step();
        wr_valid = 1'b0;
        step();
        check("ignored req busy", {31'd0, busy}, 32'd0);
        check("ignored req mem_re", {31'd0, mem_re}, 32'd0);
        check("busy ram[0301]", {24'd0, ram[16'h0301]}, 32'h78);

        // Reset during beat 2 of a 4-beat write.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0200; req_len = 4'd3;
        #1;
        step();
        req_valid = 1'b0;
        wr_valid = 1'b1; wr_data = 8'hB0;
        step();
        wr_data = 8'hB1;
        #1;
        check("pre-rst mem_we", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-rst mem_we", {31'd0, mem_we}, 32'd0);
        check("mid-rst busy", {31'd0, busy}, 32'd0);
        check("mid-rst wr_ready", {31'd0, wr_ready}, 32'd0);
        check("mid-rst mem_a", {16'd0, mem_a}, 32'd0);
        step();
        wr_data = 8'hB2;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b0;
        step();
        check("after-rst busy", {31'd0, busy}, 32'd0);
        check("after-rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst ram[0200]", {24'd0, ram[16'h0200]}, 32'hB0);
        check("rst ram[0201]", {24'd0, ram[16'h0201]}, 32'h00);
        check("rst ram[0202]", {24'd0, ram[16'h0202]}, 32'h00);
        check("rst ram[0203]", {24'd0, ram[16'h0203]}, 32'h00);

        check("we/re exclusive", excl_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
